// File: rtl/victim_cache_controller_if.sv
// victim_cache_controller_if
//   Groups the controller's bus-side signals: the L1 miss/evict port, the
//   victim cache read/write ports, the L2 read and writeback channels, the
//   response back to L1 and the BUSY status.
//   modport master : controller side (drives requests, responses, strobes)
//   modport slave  : environment side (L1, victim cache array, L2)
interface victim_cache_controller_if #(
  parameter int BLOCK_WIDTH = 512,
  parameter int TAG_WIDTH   = 26
);
  logic                   MISS_VALID;
  logic                   MISS_READY;
  logic [TAG_WIDTH-1:0]   MISS_TAG;
  logic                   EVICT_VALID;
  logic                   EVICT_DIRTY;
  logic [TAG_WIDTH-1:0]   EVICT_TAG;
  logic [BLOCK_WIDTH-1:0] EVICT_DATA;

  logic                   RESP_VALID;
  logic                   RESP_HIT;
  logic [BLOCK_WIDTH-1:0] RESP_DATA;

  logic [TAG_WIDTH-1:0]   VC_READ_TAG_ADDRESS;
  logic                   VC_READ_ENBLE;
  logic                   VC_READ_HIT;
  logic [BLOCK_WIDTH-1:0] VC_READ_DATA;
  logic [TAG_WIDTH-1:0]   VC_WRITE_TAG_ADDRESS;
  logic [BLOCK_WIDTH-1:0] VC_WRITE_DATA;
  logic                   VC_WRITE_ENABLE;

  logic                   L2_RD_VALID;
  logic                   L2_RD_READY;
  logic [TAG_WIDTH-1:0]   L2_RD_TAG;
  logic                   L2_RD_DATA_VALID;
  logic [BLOCK_WIDTH-1:0] L2_RD_DATA;
  logic                   L2_WB_VALID;
  logic                   L2_WB_READY;
  logic [TAG_WIDTH-1:0]   L2_WB_TAG;
  logic [BLOCK_WIDTH-1:0] L2_WB_DATA;

  logic                   BUSY;

  modport master (
    input  MISS_VALID, MISS_TAG, EVICT_VALID, EVICT_DIRTY, EVICT_TAG, EVICT_DATA,
    output MISS_READY,
    output RESP_VALID, RESP_HIT, RESP_DATA,
    output VC_READ_TAG_ADDRESS, VC_READ_ENBLE,
    input  VC_READ_HIT, VC_READ_DATA,
    output VC_WRITE_TAG_ADDRESS, VC_WRITE_DATA, VC_WRITE_ENABLE,
    output L2_RD_VALID, L2_RD_TAG,
    input  L2_RD_READY, L2_RD_DATA_VALID, L2_RD_DATA,
    output L2_WB_VALID, L2_WB_TAG, L2_WB_DATA,
    input  L2_WB_READY,
    output BUSY
  );

  modport slave (
    output MISS_VALID, MISS_TAG, EVICT_VALID, EVICT_DIRTY, EVICT_TAG, EVICT_DATA,
    input  MISS_READY,
    input  RESP_VALID, RESP_HIT, RESP_DATA,
    input  VC_READ_TAG_ADDRESS, VC_READ_ENBLE,
    output VC_READ_HIT, VC_READ_DATA,
    input  VC_WRITE_TAG_ADDRESS, VC_WRITE_DATA, VC_WRITE_ENABLE,
    input  L2_RD_VALID, L2_RD_TAG,
    output L2_RD_READY, L2_RD_DATA_VALID, L2_RD_DATA,
    input  L2_WB_VALID, L2_WB_TAG, L2_WB_DATA,
    output L2_WB_READY,
    input  BUSY
  );
endinterface

// File: rtl/victim_cache_controller.sv
// victim_cache_controller
//   Sequences one L1 D-cache miss at a time: probe the victim cache, fetch
//   from L2 on a victim miss, install the L1-evicted line into the victim
//   cache, write dirty evicted lines through to L2, then answer L1.
//   Ports:
//     CLK, RST       clock, asynchronous active-high reset
//     bus (master)   miss/evict, response, victim cache, L2 rd/wb, BUSY
//     VC_HIT_COUNT, VC_MISS_COUNT  saturating probe statistics, present only
//                                  when VICTIM_CACHE_STATS_EN is defined
//
//   state     | meaning
//   IDLE      | ready for a miss
//   PROBE     | victim cache read in flight (VC_LATENCY cycles)
//   L2_REQ    | L2 read request pending handshake
//   L2_WAIT   | waiting for L2 read data
//   INSTALL   | one-cycle install of the evicted line
//   WRITEBACK | dirty evicted line pending L2 writeback handshake
//   RESPOND   | one-cycle response pulse to L1
module victim_cache_controller #(
  parameter int BLOCK_WIDTH = 512,
  parameter int TAG_WIDTH   = 26,
  parameter int VC_LATENCY  = 2,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
`ifdef VICTIM_CACHE_STATS_EN
  output logic [STAT_WIDTH-1:0]   VC_HIT_COUNT,
  output logic [STAT_WIDTH-1:0]   VC_MISS_COUNT,
`endif
  victim_cache_controller_if.master bus
);

  localparam int CNT_W = (VC_LATENCY < 2) ? 1 : $clog2(VC_LATENCY);
  localparam logic [CNT_W-1:0] PROBE_LOAD = CNT_W'(VC_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, PROBE, L2_REQ, L2_WAIT, INSTALL, WRITEBACK, RESPOND
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       probe_cnt_q;

  logic [TAG_WIDTH-1:0]   miss_tag_q;
  logic                   evict_valid_q;
  logic                   evict_dirty_q;
  logic [TAG_WIDTH-1:0]   evict_tag_q;
  logic [BLOCK_WIDTH-1:0] evict_data_q;
  logic [BLOCK_WIDTH-1:0] blk_q;
  logic                   hit_q;

  logic                   miss_ready_q;
  logic                   busy_q;
  logic                   vc_rd_en_q;
  logic                   vc_we_q;
  logic                   l2_rd_valid_q;
  logic                   l2_wb_valid_q;
  logic                   resp_valid_q;
  logic                   resp_hit_q;
  logic [BLOCK_WIDTH-1:0] resp_data_q;

  // Last probe cycle: hit/miss result is sampled here.
  logic probe_done;
  assign probe_done = (state_q == PROBE) && (probe_cnt_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      probe_cnt_q   <= '0;
      miss_tag_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_dirty_q <= 1'b0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
      blk_q         <= '0;
      hit_q         <= 1'b0;
      miss_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
      vc_rd_en_q    <= 1'b0;
      vc_we_q       <= 1'b0;
      l2_rd_valid_q <= 1'b0;
      l2_wb_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.MISS_VALID && miss_ready_q) begin
            miss_tag_q    <= bus.MISS_TAG;
            evict_valid_q <= bus.EVICT_VALID;
            evict_dirty_q <= bus.EVICT_DIRTY;
            evict_tag_q   <= bus.EVICT_TAG;
            evict_data_q  <= bus.EVICT_DATA;
            hit_q         <= 1'b0;
            probe_cnt_q   <= PROBE_LOAD;
            miss_ready_q  <= 1'b0;
            busy_q        <= 1'b1;
            vc_rd_en_q    <= 1'b1;
            state_q       <= PROBE;
          end
        end
        PROBE: begin
          if (probe_cnt_q != '0) begin
            probe_cnt_q <= probe_cnt_q - 1'b1;
          end else begin
            vc_rd_en_q <= 1'b0;
            if (bus.VC_READ_HIT) begin
              blk_q   <= bus.VC_READ_DATA;
              hit_q   <= 1'b1;
              vc_we_q <= evict_valid_q;
              state_q <= INSTALL;
            end else begin
              l2_rd_valid_q <= 1'b1;
              state_q       <= L2_REQ;
            end
          end
        end
        L2_REQ: begin
          if (bus.L2_RD_READY) begin
            l2_rd_valid_q <= 1'b0;
            state_q       <= L2_WAIT;
          end
        end
        L2_WAIT: begin
          if (bus.L2_RD_DATA_VALID) begin
            blk_q   <= bus.L2_RD_DATA;
            vc_we_q <= evict_valid_q;
            state_q <= INSTALL;
          end
        end
        INSTALL: begin
          vc_we_q <= 1'b0;
          if (evict_valid_q && evict_dirty_q) begin
            l2_wb_valid_q <= 1'b1;
            state_q       <= WRITEBACK;
          end else begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= hit_q;
            resp_data_q  <= blk_q;
            state_q      <= RESPOND;
          end
        end
        WRITEBACK: begin
          if (bus.L2_WB_READY) begin
            l2_wb_valid_q <= 1'b0;
            resp_valid_q  <= 1'b1;
            resp_hit_q    <= hit_q;
            resp_data_q   <= blk_q;
            state_q       <= RESPOND;
          end
        end
        RESPOND: begin
          resp_valid_q <= 1'b0;
          miss_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          miss_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Tags and install/writeback payloads come straight from the latched
  // request; the strobes qualify them.
  assign bus.MISS_READY           = miss_ready_q;
  assign bus.BUSY                 = busy_q;
  assign bus.VC_READ_ENBLE        = vc_rd_en_q;
  assign bus.VC_READ_TAG_ADDRESS  = miss_tag_q;
  assign bus.VC_WRITE_ENABLE      = vc_we_q;
  assign bus.VC_WRITE_TAG_ADDRESS = evict_tag_q;
  assign bus.VC_WRITE_DATA        = evict_data_q;
  assign bus.L2_RD_VALID          = l2_rd_valid_q;
  assign bus.L2_RD_TAG            = miss_tag_q;
  assign bus.L2_WB_VALID          = l2_wb_valid_q;
  assign bus.L2_WB_TAG            = evict_tag_q;
  assign bus.L2_WB_DATA           = evict_data_q;
  assign bus.RESP_VALID           = resp_valid_q;
  assign bus.RESP_HIT             = resp_hit_q;
  assign bus.RESP_DATA            = resp_data_q;

`ifdef VICTIM_CACHE_STATS_EN
  logic [STAT_WIDTH-1:0] hit_cnt_q;
  logic [STAT_WIDTH-1:0] miss_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (probe_done) begin
      if (bus.VC_READ_HIT) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign VC_HIT_COUNT  = hit_cnt_q;
  assign VC_MISS_COUNT = miss_cnt_q;
`else
  logic unused_probe_done;
  assign unused_probe_done = probe_done;
`endif

endmodule

// File: tb/tb_victim_cache_controller.sv
module tb_victim_cache_controller;
  localparam int BW = 512;
  localparam int TW = 26;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  victim_cache_controller_if #(.BLOCK_WIDTH(BW), .TAG_WIDTH(TW)) bus ();

`ifdef VICTIM_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  victim_cache_controller #(
    .BLOCK_WIDTH(BW), .TAG_WIDTH(TW), .VC_LATENCY(2), .STAT_WIDTH(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef VICTIM_CACHE_STATS_EN
    .VC_HIT_COUNT(hit_count),
    .VC_MISS_COUNT(miss_count),
`endif
    .bus(bus)
  );

  localparam logic [BW-1:0] D_A5  = {64{8'hA5}};
  localparam logic [BW-1:0] D_5A  = {64{8'h5A}};
  localparam logic [BW-1:0] D_3C  = {64{8'h3C}};
  localparam logic [BW-1:0] D_77  = {64{8'h77}};
  localparam logic [BW-1:0] D_99  = {64{8'h99}};
  localparam logic [BW-1:0] D_BAD = {64{8'hBD}};

  // Victim cache model: tags 0x1 and 0x5 are resident.
  always_comb begin
    bus.VC_READ_HIT  = 1'b0;
    bus.VC_READ_DATA = '0;
    if (bus.VC_READ_ENBLE && bus.VC_READ_TAG_ADDRESS == 26'h1) begin
      bus.VC_READ_HIT  = 1'b1;
      bus.VC_READ_DATA = D_A5;
    end else if (bus.VC_READ_ENBLE && bus.VC_READ_TAG_ADDRESS == 26'h5) begin
      bus.VC_READ_HIT  = 1'b1;
      bus.VC_READ_DATA = D_5A;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event counters observed at clock edges.
  int vc_we_cnt = 0;
  logic [TW-1:0] vc_we_tag_last = '0;
  int l2_cnt = 0;
  int acc_cnt = 0;
  always @(posedge CLK) begin
    if (!RST) begin
      if (bus.VC_WRITE_ENABLE) begin
        vc_we_cnt <= vc_we_cnt + 1;
        vc_we_tag_last <= bus.VC_WRITE_TAG_ADDRESS;
      end
      if (bus.L2_RD_VALID || bus.L2_WB_VALID) l2_cnt <= l2_cnt + 1;
      if (bus.MISS_VALID && bus.MISS_READY) acc_cnt <= acc_cnt + 1;
    end
  end

  // Scoreboard: expected {hit, data} per response.
  typedef struct packed { logic hit; logic [BW-1:0] data; } resp_t;
  resp_t exp_q[$];

  always @(negedge CLK) begin
    if (!RST && bus.RESP_VALID) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_resp", BW'(bus.RESP_VALID), '0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check(bus.RESP_HIT == e.hit, "resp_hit", BW'(bus.RESP_HIT), BW'(e.hit));
        check(bus.RESP_DATA == e.data, "resp_data", bus.RESP_DATA, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_resp(input string name);
    int i;
    for (i = 0; i < 60; i++) begin
      if (bus.RESP_VALID) break;
      tick();
    end
    check(bus.RESP_VALID == 1'b1, name, BW'(bus.RESP_VALID), BW'(1));
  endtask

  task automatic wait_sig(input bit which_wb, input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      if ((which_wb ? bus.L2_WB_VALID : bus.L2_RD_VALID) == 1'b1) break;
      tick();
    end
    check((which_wb ? bus.L2_WB_VALID : bus.L2_RD_VALID) == 1'b1, name, '0, BW'(1));
  endtask

  task automatic issue(input logic [TW-1:0] tag, input logic ev, input logic dirty,
                       input logic [TW-1:0] etag, input logic [BW-1:0] edata);
    bus.MISS_VALID  = 1'b1;
    bus.MISS_TAG    = tag;
    bus.EVICT_VALID = ev;
    bus.EVICT_DIRTY = dirty;
    bus.EVICT_TAG   = etag;
    bus.EVICT_DATA  = edata;
  endtask

  int we0, l20;

  initial begin
    bus.MISS_VALID = 0; bus.MISS_TAG = '0; bus.EVICT_VALID = 0; bus.EVICT_DIRTY = 0;
    bus.EVICT_TAG = '0; bus.EVICT_DATA = '0;
    bus.L2_RD_READY = 0; bus.L2_RD_DATA_VALID = 0; bus.L2_RD_DATA = '0; bus.L2_WB_READY = 0;

    repeat (3) tick();
    RST = 1'b0;
    tick();
    check(bus.MISS_READY == 1'b1, "rst_miss_ready", BW'(bus.MISS_READY), BW'(1));
    check(bus.BUSY == 1'b0, "rst_busy", BW'(bus.BUSY), '0);
    check(bus.RESP_VALID == 1'b0 && bus.VC_READ_ENBLE == 1'b0, "rst_outputs", '0, '0);

    // 1: victim hit, clean evict tag 0x7.
    we0 = vc_we_cnt; l20 = l2_cnt;
    issue(26'h1, 1'b1, 1'b0, 26'h7, D_77);
    exp_q.push_back('{hit: 1'b1, data: D_A5});
    tick();                      // handshake edge, now T+1
    bus.MISS_VALID = 0;
    check(bus.VC_READ_ENBLE == 1'b1, "t1_vc_rd_en", BW'(bus.VC_READ_ENBLE), BW'(1));
    check(bus.MISS_READY == 1'b0, "t1_miss_ready_low", BW'(bus.MISS_READY), '0);
    tick();                      // T+2
    tick();                      // T+3
    check(bus.VC_WRITE_ENABLE == 1'b1, "t1_vc_we_at_T3", BW'(bus.VC_WRITE_ENABLE), BW'(1));
    check(bus.VC_WRITE_TAG_ADDRESS == 26'h7, "t1_vc_we_tag", BW'(bus.VC_WRITE_TAG_ADDRESS), BW'(7));
    check(bus.VC_WRITE_DATA == D_77, "t1_vc_we_data", bus.VC_WRITE_DATA, D_77);
    tick();                      // T+4
    check(bus.RESP_VALID == 1'b1, "t1_resp_at_T4", BW'(bus.RESP_VALID), BW'(1));
    tick();
    check(l2_cnt == l20, "t1_no_l2", BW'(l2_cnt - l20), '0);
    check(vc_we_cnt == we0 + 1, "t1_one_install", BW'(vc_we_cnt - we0), BW'(1));

    // 2: victim miss tag 0x2, L2 ready stalled 3 cycles, data after handshake.
    issue(26'h2, 1'b0, 1'b0, 26'h0, '0);
    exp_q.push_back('{hit: 1'b0, data: D_3C});
    tick();
    bus.MISS_VALID = 0;
    wait_sig(1'b0, "t2_rd_valid_timeout");
    for (int i = 0; i < 3; i++) begin
      tick();
      check(bus.L2_RD_VALID == 1'b1 && bus.L2_RD_TAG == 26'h2, "t2_rd_held",
            BW'({bus.L2_RD_VALID, bus.L2_RD_TAG}), BW'({1'b1, 26'h2}));
    end
    bus.L2_RD_READY = 1; bus.L2_RD_DATA_VALID = 1; bus.L2_RD_DATA = D_BAD;
    tick();                      // handshake; same-cycle data must be ignored
    bus.L2_RD_READY = 0; bus.L2_RD_DATA_VALID = 0;
    check(bus.L2_RD_VALID == 1'b0, "t2_rd_drop", BW'(bus.L2_RD_VALID), '0);
    repeat (4) tick();
    check(bus.RESP_VALID == 1'b0 && bus.BUSY == 1'b1, "t2_still_waiting", BW'(bus.RESP_VALID), '0);
    bus.L2_RD_DATA_VALID = 1; bus.L2_RD_DATA = D_3C;
    tick();
    bus.L2_RD_DATA_VALID = 0;
    wait_resp("t2_resp_timeout");
    tick();

    // 3: victim hit tag 0x5, dirty evict tag 0x9, writeback stalled 4 cycles.
    we0 = vc_we_cnt;
    issue(26'h5, 1'b1, 1'b1, 26'h9, D_99);
    exp_q.push_back('{hit: 1'b1, data: D_5A});
    tick();
    bus.MISS_VALID = 0;
    wait_sig(1'b1, "t3_wb_valid_timeout");
    check(vc_we_cnt == we0 + 1 && vc_we_tag_last == 26'h9, "t3_install", BW'(vc_we_tag_last), BW'(9));
    for (int i = 0; i < 4; i++) begin
      check(bus.L2_WB_VALID == 1'b1 && bus.L2_WB_TAG == 26'h9 && bus.L2_WB_DATA == D_99,
            "t3_wb_held", BW'(bus.L2_WB_TAG), BW'(9));
      check(bus.RESP_VALID == 1'b0, "t3_no_early_resp", BW'(bus.RESP_VALID), '0);
      tick();
    end
    bus.L2_WB_READY = 1;
    tick();
    bus.L2_WB_READY = 0;
    check(bus.L2_WB_VALID == 1'b0, "t3_wb_drop", BW'(bus.L2_WB_VALID), '0);
    wait_resp("t3_resp_timeout");
    tick();

    // 4: MISS_VALID held high back-to-back, no evictions.
    we0 = vc_we_cnt;
    acc_cnt = 0;
    issue(26'h1, 1'b0, 1'b0, 26'h0, '0);
    exp_q.push_back('{hit: 1'b1, data: D_A5});
    exp_q.push_back('{hit: 1'b1, data: D_5A});
    tick();
    check(bus.MISS_READY == 1'b0, "t4_ready_low_probe", BW'(bus.MISS_READY), '0);
    wait_resp("t4_resp1_timeout");
    check(bus.MISS_READY == 1'b0, "t4_ready_low_respond", BW'(bus.MISS_READY), '0);
    check(acc_cnt == 1, "t4_one_accept", BW'(acc_cnt), BW'(1));
    bus.MISS_TAG = 26'h5;
    tick();
    check(bus.MISS_READY == 1'b1, "t4_ready_idle", BW'(bus.MISS_READY), BW'(1));
    tick();
    bus.MISS_VALID = 0;
    check(acc_cnt == 2, "t4_second_accept", BW'(acc_cnt), BW'(2));
    wait_resp("t4_resp2_timeout");
    tick();
    check(vc_we_cnt == we0, "t4_no_install", BW'(vc_we_cnt - we0), '0);

`ifdef VICTIM_CACHE_STATS_EN
    check(hit_count == 32'd4, "stats_hits", BW'(hit_count), BW'(4));
    check(miss_count == 32'd1, "stats_misses", BW'(miss_count), BW'(1));
`endif

    // 5: reset during L2_WAIT.
    bus.L2_RD_READY = 1;
    issue(26'h3, 1'b0, 1'b0, 26'h0, '0);
    tick();
    bus.MISS_VALID = 0;
    wait_sig(1'b0, "t5_rd_valid_timeout");
    tick();                      // handshake with READY=1, now L2_WAIT
    bus.L2_RD_READY = 0;
    check(bus.BUSY == 1'b1, "t5_in_wait", BW'(bus.BUSY), BW'(1));
    #2 RST = 1'b1;
    #1;
    check(bus.BUSY == 1'b0 && bus.L2_RD_VALID == 1'b0 && bus.VC_READ_ENBLE == 1'b0 &&
          bus.RESP_VALID == 1'b0 && bus.RESP_HIT == 1'b0, "t5_async_clear", BW'(bus.BUSY), '0);
    check(bus.RESP_DATA == '0, "t5_resp_data_clear", bus.RESP_DATA, '0);
`ifdef VICTIM_CACHE_STATS_EN
    check(hit_count == 0 && miss_count == 0, "stats_cleared", BW'(hit_count), '0);
`endif
    tick();
    RST = 1'b0;
    check(bus.MISS_READY == 1'b1, "t5_ready_after_rst", BW'(bus.MISS_READY), BW'(1));
    bus.L2_RD_DATA_VALID = 1; bus.L2_RD_DATA = D_BAD;
    tick();
    bus.L2_RD_DATA_VALID = 0;
    repeat (5) tick();
    check(bus.BUSY == 1'b0, "t5_late_data_ignored", BW'(bus.BUSY), '0);
    check(exp_q.size() == 0, "scoreboard_drained", BW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
